// File: rtl/aes_pkg.sv
// AES byte-substitution tables and lookup helpers, shared across the AES-128 datapath.
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic byte_t sbox_fwd(input byte_t b);
    return SBOX[b];
  endfunction

  function automatic byte_t sbox_inv(input byte_t b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// Single-byte S-box lookup, purely combinational.
// SBOX_INV_EN adds the inverse table, selected by inv; otherwise inv is ignored.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

`ifdef SBOX_INV_EN
  assign dout = inv ? sbox_inv(din) : sbox_fwd(din);
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign dout = sbox_fwd(din);
`endif

endmodule

// File: rtl/sbox_sub_pipe.sv
// Pipelined AES SubBytes engine: LANES bytes per beat, STAGES-deep valid/ready pipeline.
// SBOX_INV_EN enables per-beat inverse substitution via in_inv.
module sbox_sub_pipe
  import aes_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               busy,
  output logic [CNT_W-1:0]   beat_cnt
);

  logic               lane_inv;
  logic [8*LANES-1:0] sub_data;

`ifdef SBOX_INV_EN
  assign lane_inv = in_inv;
`else
  logic unused_inv;
  assign unused_inv = in_inv;
  assign lane_inv   = 1'b0;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_lane u_lane (
      .din  (in_data[8*i +: 8]),
      .inv  (lane_inv),
      .dout (sub_data[8*i +: 8])
    );
  end

  logic [STAGES-1:0]  v;
  logic [8*LANES-1:0] d [STAGES];
  logic [STAGES:0]    rdy;

  // rdy[k]: stage k can take a beat this cycle (empty, or its beat moves on)
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v[k] || rdy[k+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d[k] <= '0;
      end
    end else begin
      if (rdy[0]) begin
        v[0] <= in_valid;
        if (in_valid) d[0] <= sub_data;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) d[k] <= d[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];
  assign busy      = |v;

endmodule

// File: tb/tb_sbox_sub_pipe.sv
// Self-checking bench for sbox_sub_pipe: vector table, scoreboard-checked streams,
// stall/reset corner cases, and a CNT_W=4 instance for counter wrap.
module tb_sbox_sub_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_data;
  logic [15:0] beat_cnt;

  logic        in4_valid = 1'b0, out4_ready = 1'b1;
  logic [31:0] in4_data = '0;
  logic        in4_ready, out4_valid, busy4;
  logic [31:0] out4_data;
  logic [3:0]  beat_cnt4;

  sbox_sub_pipe #(.LANES(4), .STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .beat_cnt(beat_cnt)
  );

  sbox_sub_pipe #(.LANES(4), .STAGES(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in4_valid), .in_ready(in4_ready), .in_data(in4_data),
    .in_inv(1'b0), .out_valid(out4_valid), .out_ready(out4_ready), .out_data(out4_data),
    .busy(busy4), .beat_cnt(beat_cnt4)
  );

  int errors = 0;
  int checks = 0;
  int delivered = 0;
  int delivered4 = 0;
  logic [31:0] exp_q[$];
  logic [7:0] sb_model [256];
  logic [7:0] isb_model [256];

  typedef struct {
    logic [31:0] din;
    logic        inv;
    logic [31:0] dout;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    if (x == 8'h00) r = 8'h00;
    else for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] din, input logic inv);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) begin
`ifdef SBOX_INV_EN
      r[8*l +: 8] = inv ? isb_model[din[8*l +: 8]] : sb_model[din[8*l +: 8]];
`else
      r[8*l +: 8] = sb_model[din[8*l +: 8]];
`endif
    end
    return r;
  endfunction

  // scoreboard: outputs compared in order against what was accepted
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", out_data);
        end else begin
          check("scoreboard", out_data, exp_q.pop_front());
        end
        delivered++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data, in_inv));
      if (out4_valid && out4_ready) delivered4++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] din, input logic inv, output bit ok);
    bit acc;
    in_valid = 1'b1; in_data = din; in_inv = inv;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk); acc = in_ready;
      step();
      ok = acc;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic drain(input string name);
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < 200) begin step(); c++; end
    check(name, {31'd0, busy} | 64'(exp_q.size()), 0);
  endtask

  initial begin
    bit ok;
    logic [31:0] held, d;
    int sent, cyc;

    for (int i = 0; i < 256; i++) sb_model[i] = calc_sbox(8'(i));
    for (int i = 0; i < 256; i++) isb_model[sb_model[i]] = 8'(i);

    vecs.push_back('{32'hFF53_0100, 1'b0, 32'h16ED_7C63});
    vecs.push_back('{32'h0000_0000, 1'b0, 32'h6363_6363});
    vecs.push_back('{32'h1020_3040, 1'b0, 32'hCAB7_0409});
    vecs.push_back('{32'h8090_A0B0, 1'b0, 32'hCD60_E0E7});
    vecs.push_back('{32'hFFFF_FFFF, 1'b0, 32'h1616_1616});
`ifdef SBOX_INV_EN
    vecs.push_back('{32'h16ED_7C63, 1'b1, 32'hFF53_0100});
    vecs.push_back('{32'h6363_6363, 1'b1, 32'h0000_0000});
`endif

    // reset state
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    // counter wrap on the CNT_W=4 instance
    in4_valid = 1'b1;
    for (int c = 0; c < 24; c++) begin
      in4_data = $urandom;
      step();
      check("cnt4_wrap", beat_cnt4, delivered4 % 16);
    end
    in4_valid = 1'b0;
    check("cnt4_wrapped_seen", delivered4 > 16, 1);

    // vector table, single beats with latency check
    foreach (vecs[i]) begin
      in_valid = 1'b1; in_data = vecs[i].din; in_inv = vecs[i].inv;
      check("vec_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("vec_lat1_valid", out_valid, 0);
      step();
      check("vec_lat2_valid", out_valid, 1);
      check("vec_data", out_data, vecs[i].dout);
      step();
      check("vec_after_valid", out_valid, 0);
      if (i == 0) check("vec_beat_cnt1", beat_cnt, 1);
    end

`ifdef SBOX_INV_EN
    // alternating modes back to back
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b1; in_inv = n[0]; in_data = $urandom;
      step();
    end
    in_valid = 1'b0;
    drain("inv_alt_drain");
`endif

    // full-rate stream of 256 beats
    out_ready = 1'b1;
    for (int n = 0; n < 256; n++) begin
      in_valid = 1'b1; in_data = {4{8'(n)}}; in_inv = 1'b0;
      check("stream_in_ready", in_ready, 1);
      if (n >= 2) check("stream_out_valid", out_valid, 1);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    check("stream_empty", 64'(exp_q.size()) | {63'd0, busy}, 0);
    check("stream_beat_cnt", beat_cnt, 16'(delivered));
    check("stream_delivered", delivered, 256 + vecs.size());

    // stall with three beats offered
    out_ready = 1'b0;
    send(32'hA1A2_A3A4, 1'b0, ok);
    send(32'hB1B2_B3B4, 1'b0, ok);
    in_valid = 1'b1; in_data = 32'hC1C2_C3C4;
    check("stall_in_ready", in_ready, 0);
    check("stall_busy", busy, 1);
    check("stall_out_valid", out_valid, 1);
    held = model(32'hA1A2_A3A4, 1'b0);
    for (int c = 0; c < 4; c++) begin
      check("stall_out_data", out_data, held);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(32'hC1C2_C3C4, 1'b0, ok);
    drain("stall_drain");
    check("stall_beat_cnt", beat_cnt, 16'(delivered));

    // random valid/ready traffic
    sent = 0; cyc = 0;
    in_valid = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      bit acc;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; in_data = $urandom; in_inv = $urandom_range(0, 1);
      end
      @(negedge clk); acc = in_valid && in_ready;
      step();
      cyc++;
      if (acc) begin sent++; in_valid = 1'b0; end
    end
    in_valid = 1'b0;
    check("random_sent", sent, 10000);
    out_ready = 1'b1;
    drain("random_drain");
    check("random_beat_cnt", beat_cnt, 16'(delivered));

    // reset with pipe full
    out_ready = 1'b0;
    send(32'h1111_1111, 1'b0, ok);
    send(32'h2222_2222, 1'b0, ok);
    check("prerst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_beat_cnt", beat_cnt, 0);
    exp_q.delete();
    delivered = 0;
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("postrst_no_output", out_valid, 0);
    end
    d = 32'h3C4D_5E6F;
    send(d, 1'b0, ok);
    check("postrst_lat1", out_valid, 0);
    step();
    check("postrst_valid", out_valid, 1);
    check("postrst_data", out_data, model(d, 1'b0));
    step();
    check("postrst_beat_cnt", beat_cnt, 1);
    drain("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
